// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam int         CMD_RD_BIT = 7;
  localparam logic [6:0] ID_ADDR    = 7'h7F;
  localparam int         REG_LED    = 0;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between spi_slave and the register bridge, plus the bridge's
// register-side outputs (LEDs, write strobe, frame activity).
interface spi_reg_bridge_if;
  logic       csn;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [7:0] led_reg;
  logic       wr_pulse;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  csn, rx_data, rx_ready,
    output tx_data, led_reg, wr_pulse, wr_addr, wr_data, busy
  );

  modport master (
    output csn, rx_data, rx_ready,
    input  tx_data, led_reg, wr_pulse, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;
endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes CS-framed SPI byte streams into reads/writes of a small 8-bit
// register file; register 0 drives the board LEDs.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic            clk,
  input  logic            rstn,
  spi_reg_bridge_if.slave bus
);
  logic       csn_sync;
  logic       cs_prev_q, cs_prev_d;
  logic       cs_fall, cs_rise, take_byte, wr_en;
  state_e     state_q, state_d, state_nxt;
  logic [6:0] addr_q, addr_d, rx_addr, next_addr;
  logic [7:0] tx_data_q, tx_data_d, tx_nxt;
  logic       wr_pulse_q, wr_pulse_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  sync_2ff #(.RST_VAL(1'b1)) u_csn_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.csn),
    .q    (csn_sync)
  );

  // Unimplemented addresses read as zero; the top address returns the ID byte.
  function automatic logic [7:0] rd_byte(input logic [6:0] a);
    logic [7:0] val;
    val = (a == ID_ADDR) ? ID_VALUE : 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      val = (a == 7'(i)) ? regs_q[i] : val;
    end
    return val;
  endfunction

  assign rx_addr   = bus.rx_data[6:0];
  assign next_addr = addr_q + 7'd1;
  assign cs_fall   = cs_prev_q & ~csn_sync;
  assign cs_rise   = ~cs_prev_q & csn_sync;
  // A byte arriving with the frame start belongs to no frame and is dropped.
  assign take_byte = bus.rx_ready & ~cs_fall;
  assign wr_en     = take_byte & (state_q == ST_WR);

  always_comb begin
    cs_prev_d = csn_sync;
    state_nxt = state_q;
    addr_d    = addr_q;
    tx_nxt    = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        tx_nxt = ID_VALUE;
      end
      ST_CMD: begin
        if (take_byte) begin
          addr_d    = rx_addr;
          state_nxt = bus.rx_data[CMD_RD_BIT] ? ST_RD : ST_WR;
          tx_nxt    = bus.rx_data[CMD_RD_BIT] ? rd_byte(rx_addr) : tx_data_q;
        end else begin
          state_nxt = ST_CMD;
        end
      end
      ST_RD: begin
        if (take_byte) begin
          addr_d = next_addr;
          tx_nxt = rd_byte(next_addr);
        end else begin
          state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        if (take_byte) begin
          addr_d = next_addr;
          tx_nxt = bus.rx_data;
        end else begin
          state_nxt = ST_WR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = ID_VALUE;
      end
    endcase

    // Frame edges override the byte result; a byte coincident with cs_rise
    // has already been applied to the registers and wr_* above.
    state_d   = cs_fall ? ST_CMD : (cs_rise ? ST_IDLE : state_nxt);
    tx_data_d = (cs_fall | cs_rise) ? ID_VALUE : tx_nxt;

    wr_pulse_d = wr_en;
    wr_addr_d  = wr_en ? addr_q : wr_addr_q;
    wr_data_d  = wr_en ? bus.rx_data : wr_data_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr_en && (addr_q == 7'(i))) ? bus.rx_data : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      addr_q     <= 7'd0;
      tx_data_q  <= ID_VALUE;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      cs_prev_q  <= cs_prev_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.led_reg  = regs_q[REG_LED];
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = ~csn_sync;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomised self-checking bench for spi_reg_bridge against a frame-level
// model of the register file and MISO byte sequence.
module tb_spi_reg_bridge;
  localparam int         NUM_REGS = 16;
  localparam logic [7:0] ID       = 8'hA5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  spi_reg_bridge_if bus_if ();

  spi_reg_bridge #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] mem [NUM_REGS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_rd(input int a);
    if (a < NUM_REGS) return mem[a];
    else if (a == 127) return ID;
    else return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'h00;
  endtask

  // One CS-framed transaction; optionally the last byte lands on the cs_rise clock.
  task automatic run_frame(input logic [7:0] frame_q[$], input bit end_on_rise);
    int         addr;
    bit         is_rd;
    bit         exp_wr;
    int         exp_wa;
    logic [7:0] exp_tx;
    logic [7:0] cmd;
    bit         last_rise;
    addr  = 0;
    is_rd = 1'b0;
    bus_if.csn = 1'b0;
    repeat (4) tick();
    check_eq("busy_in_frame", bus_if.busy, 1);
    check_eq("tx_frame_start", bus_if.tx_data, ID);
    foreach (frame_q[i]) begin
      last_rise = end_on_rise && (i == frame_q.size() - 1);
      if (last_rise) begin
        bus_if.csn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
      end
      bus_if.rx_data  = frame_q[i];
      bus_if.rx_ready = 1'b1;
      tick();
      bus_if.rx_ready = 1'b0;
      exp_wr = 1'b0;
      exp_wa = 0;
      if (i == 0) begin
        cmd    = frame_q[i];
        addr   = int'(cmd[6:0]);
        is_rd  = cmd[7];
        exp_tx = is_rd ? model_rd(addr) : ID;
      end else if (is_rd) begin
        addr   = (addr + 1) % 128;
        exp_tx = model_rd(addr);
      end else begin
        exp_wr = 1'b1;
        exp_wa = addr;
        if (addr < NUM_REGS) mem[addr] = frame_q[i];
        exp_tx = frame_q[i];
        addr   = (addr + 1) % 128;
      end
      if (last_rise) exp_tx = ID;
      check_eq("tx_data", bus_if.tx_data, exp_tx);
      check_eq("wr_pulse", bus_if.wr_pulse, exp_wr);
      if (exp_wr) begin
        check_eq("wr_addr", bus_if.wr_addr, exp_wa);
        check_eq("wr_data", bus_if.wr_data, frame_q[i]);
      end
      check_eq("led_reg", bus_if.led_reg, mem[0]);
      tick();
      check_eq("wr_pulse_one_clk", bus_if.wr_pulse, 0);
    end
    bus_if.csn = 1'b1;
    repeat (4) tick();
    check_eq("tx_after_frame", bus_if.tx_data, ID);
    check_eq("busy_after_frame", bus_if.busy, 0);
  endtask

  task automatic readback_all();
    logic [7:0] q[$];
    q.push_back(8'h80);
    for (int i = 0; i < NUM_REGS; i++) q.push_back(8'($urandom));
    run_frame(q, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         len;
    int         sel;
    logic [7:0] cmd;

    bus_if.csn      = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_ready = 1'b0;
    clear_model();

    // Reset values, then idle bytes must be ignored
    repeat (3) tick();
    check_eq("rst_tx", bus_if.tx_data, ID);
    check_eq("rst_led", bus_if.led_reg, 0);
    check_eq("rst_busy", bus_if.busy, 0);
    check_eq("rst_wr_pulse", bus_if.wr_pulse, 0);
    check_eq("rst_wr_addr", bus_if.wr_addr, 0);
    check_eq("rst_wr_data", bus_if.wr_data, 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.rx_data  = 8'(8'h11 * i);
      bus_if.rx_ready = 1'b1;
      tick();
      bus_if.rx_ready = 1'b0;
      check_eq("idle_wr_pulse", bus_if.wr_pulse, 0);
      check_eq("idle_tx", bus_if.tx_data, ID);
    end

    // LED write, burst + readback, ID address wrap, out-of-range write
    q = '{8'h00, 8'h22};                         run_frame(q, 1'b0);
    check_eq("led_22", bus_if.led_reg, 8'h22);
    q = '{8'h03, 8'h11, 8'h22, 8'h33};           run_frame(q, 1'b0);
    q = '{8'h83, 8'h00, 8'h00, 8'h00};           run_frame(q, 1'b0);
    q = '{8'hFF, 8'h00, 8'h00};                  run_frame(q, 1'b0);
    q = '{8'h20, 8'h5A};                         run_frame(q, 1'b0);
    q = '{8'hA0, 8'h00};                         run_frame(q, 1'b0);
    q = '{8'h7E, 8'h99, 8'h77, 8'h44};           run_frame(q, 1'b0);
    readback_all();

    // Reset mid write-burst
    bus_if.csn = 1'b0;
    repeat (4) tick();
    bus_if.rx_data = 8'h05; bus_if.rx_ready = 1'b1; tick(); bus_if.rx_ready = 1'b0; tick();
    bus_if.rx_data = 8'h77; bus_if.rx_ready = 1'b1; tick(); bus_if.rx_ready = 1'b0;
    check_eq("pre_rst_echo", bus_if.tx_data, 8'h77);
    rstn = 1'b0;
    #1;
    clear_model();
    check_eq("midrst_tx", bus_if.tx_data, ID);
    check_eq("midrst_led", bus_if.led_reg, 0);
    check_eq("midrst_busy", bus_if.busy, 0);
    bus_if.csn = 1'b1;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.rx_data  = 8'($urandom);
      bus_if.rx_ready = 1'b1;
      tick();
      bus_if.rx_ready = 1'b0;
      check_eq("postrst_wr_pulse", bus_if.wr_pulse, 0);
      check_eq("postrst_tx", bus_if.tx_data, ID);
    end
    readback_all();

    // Byte coincident with cs_rise commits; command-only and empty frames are inert
    q = '{8'h04, 8'h66, 8'h77};                  run_frame(q, 1'b1);
    q = '{8'h00};                                run_frame(q, 1'b0);
    q = '{8'h01};                                run_frame(q, 1'b1);
    q.delete();                                  run_frame(q, 1'b0);
    readback_all();

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      q.delete();
      len = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       cmd = 8'($urandom_range(124, 127));
        1:       cmd = 8'($urandom_range(0, NUM_REGS - 1));
        2:       cmd = 8'($urandom_range(NUM_REGS, 127));
        default: cmd = 8'($urandom_range(0, NUM_REGS - 1));
      endcase
      cmd[7] = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) q.push_back(b == 0 ? cmd : 8'($urandom));
      run_frame(q, 1'($urandom_range(0, 1)));
    end
    readback_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
